// File: rtl/ika9958_pkg.sv
// ---------------------------------------------------------------------------
// ika9958_pkg
// Shared types and constants for the IKA9958 CPU-side register controller.
//   port_e    : CPU port select encoding (data / control / palette / indirect)
//   state_e   : pointer-increment state machine states
//   strobe_t  : one captured CPU access (used for the pending buffer)
//   REG_*PTR  : register-file indices of the status, palette and indirect
//               pointer registers
// ---------------------------------------------------------------------------
package ika9958_pkg;

  typedef enum logic [1:0] {
    PORT_DATA = 2'd0,
    PORT_CTRL = 2'd1,
    PORT_PAL  = 2'd2,
    PORT_IND  = 2'd3
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INC16 = 2'd1,
    ST_INC17 = 2'd2
  } state_e;

  localparam logic [5:0] REG_STATPTR = 6'd15;
  localparam logic [5:0] REG_PALPTR  = 6'd16;
  localparam logic [5:0] REG_INDPTR  = 6'd17;

  typedef struct packed {
    logic       valid;
    port_e      port;
    logic       wr;     // 1 = write, 0 = read
    logic [7:0] data;
  } strobe_t;

  // Palette pointer advance: 4-bit wrap, upper nibble of R#16 stays zero.
  function automatic logic [7:0] pal_ptr_inc(input logic [3:0] r16);
    logic [3:0] nxt;
    nxt = r16 + 4'd1;
    return {4'd0, nxt};
  endfunction

  // Indirect pointer advance: only the 6-bit target wraps, bits 7:6 kept.
  function automatic logic [7:0] ind_ptr_inc(input logic [7:0] r17);
    logic [5:0] nxt;
    nxt = r17[5:0] + 6'd1;
    return {r17[7:6], nxt};
  endfunction

  // Palette word {G, R, B}: G from the second byte, R/B from the first.
  function automatic logic [8:0] pal_pack(input logic [7:0] p1, input logic [7:0] di);
    return {di[2:0], p1[6:4], p1[2:0]};
  endfunction

endpackage

// File: rtl/ika9958_regctrl.sv
// ---------------------------------------------------------------------------
// ika9958_regctrl
// CPU port decoder for the IKA9958 register file, VRAM address setup,
// palette and status read paths, with automatic R#16/R#17 pointer advance.
//
// Ports
//   i_EMUCLK   : clock, all state changes on its rising edge
//   i_RST_n    : synchronous active-low reset
//   i_WR/i_RD  : one-cycle CPU write/read strobes (both high = write)
//   i_PORT     : 0 data, 1 control, 2 palette, 3 indirect
//   i_DI       : CPU write data
//   i_R15/16/17: status, palette and indirect pointers from the register file
//   o_REG_*    : register-file write pulse, address, data
//   o_VA_*     : VRAM address setup pulse, address, direction (1 = write)
//   o_PAL_*    : palette write pulse, address, {G,R,B} data
//   o_STAT_*   : status read pulse and register select
//   o_BUSY     : high during the pointer-increment cycle
//
// Every output is registered; an access seen at edge N shows its result
// after edge N. A pointer increment takes the following cycle, during which
// new strobes are parked in a one-entry pending buffer.
// ---------------------------------------------------------------------------
module ika9958_regctrl
  import ika9958_pkg::*;
(
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_WR,
  input  logic        i_RD,
  input  logic [1:0]  i_PORT,
  input  logic [7:0]  i_DI,
  input  logic [3:0]  i_R15,
  input  logic [3:0]  i_R16,
  input  logic [7:0]  i_R17,
  output logic        o_REG_WE,
  output logic [5:0]  o_REG_ADDR,
  output logic [7:0]  o_REG_DATA,
  output logic        o_VA_WE,
  output logic [13:0] o_VA,
  output logic        o_VA_WR,
  output logic        o_PAL_WE,
  output logic [3:0]  o_PAL_ADDR,
  output logic [8:0]  o_PAL_DATA,
  output logic        o_STAT_RD,
  output logic [3:0]  o_STAT_SEL,
  output logic        o_BUSY
);

  // State machine
  state_e  state_reg, state_next;

  // Command path
  strobe_t live;       // access presented on the pins this cycle
  strobe_t cmd;        // access actually executed this cycle
  strobe_t pend_reg, pend_next;

  // Two-byte sequencing for the control and palette ports
  logic       f1_reg, f1_next;
  logic       f2_reg, f2_next;
  logic [7:0] b1_reg, b1_next;
  logic [7:0] p1_reg, p1_next;

  // Output registers
  logic        reg_we_reg,   reg_we_next;
  logic [5:0]  reg_addr_reg, reg_addr_next;
  logic [7:0]  reg_data_reg, reg_data_next;
  logic        va_we_reg,    va_we_next;
  logic [13:0] va_reg,       va_next;
  logic        va_wr_reg,    va_wr_next;
  logic        pal_we_reg,   pal_we_next;
  logic [3:0]  pal_addr_reg, pal_addr_next;
  logic [8:0]  pal_data_reg, pal_data_next;
  logic        stat_rd_reg,  stat_rd_next;
  logic [3:0]  stat_sel_reg, stat_sel_next;
  logic        busy_reg,     busy_next;

  // -------------------------------------------------------------------------
  // Command arbitration. In IDLE a parked access wins over the pins, and any
  // pin access in that same cycle is lost because the buffer is still full.
  // Outside IDLE nothing executes; a pin access is parked if there is room.
  // -------------------------------------------------------------------------
  always_comb begin
    live.valid = i_WR | i_RD;
    live.port  = port_e'(i_PORT);
    live.wr    = i_WR;
    live.data  = i_DI;

    cmd       = '0;
    pend_next = pend_reg;

    if (state_reg == ST_IDLE) begin
      if (pend_reg.valid) begin
        cmd       = pend_reg;
        pend_next = '0;
      end else begin
        cmd = live;
      end
    end else if (!pend_reg.valid) begin
      pend_next = live;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Increment states last one cycle; only a completed
  // palette pair or an auto-incrementing indirect write starts one.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = ST_IDLE;
    if (cmd.valid && cmd.wr) begin
      case (cmd.port)
        PORT_PAL: begin
          if (f2_reg) begin
            state_next = ST_INC16;
          end
        end
        PORT_IND: begin
          if ((i_R17[5:0] != REG_INDPTR) && !i_R17[7]) begin
            state_next = ST_INC17;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    reg_we_next   = 1'b0;
    reg_addr_next = reg_addr_reg;
    reg_data_next = reg_data_reg;
    va_we_next    = 1'b0;
    va_next       = va_reg;
    va_wr_next    = va_wr_reg;
    pal_we_next   = 1'b0;
    pal_addr_next = pal_addr_reg;
    pal_data_next = pal_data_reg;
    stat_rd_next  = 1'b0;
    stat_sel_next = stat_sel_reg;
    f1_next       = f1_reg;
    f2_next       = f2_reg;
    b1_next       = b1_reg;
    p1_next       = p1_reg;
    busy_next     = (state_next != ST_IDLE);

    case (state_reg)
      ST_INC16: begin
        reg_we_next   = 1'b1;
        reg_addr_next = REG_PALPTR;
        reg_data_next = pal_ptr_inc(i_R16);
      end

      ST_INC17: begin
        reg_we_next   = 1'b1;
        reg_addr_next = REG_INDPTR;
        reg_data_next = ind_ptr_inc(i_R17);
      end

      default: begin
        if (cmd.valid) begin
          case (cmd.port)
            PORT_DATA: begin
              // Data-port traffic resynchronises the control-port byte pair.
              f1_next = 1'b0;
            end

            PORT_CTRL: begin
              if (cmd.wr) begin
                if (!f1_reg) begin
                  b1_next = cmd.data;
                  f1_next = 1'b1;
                end else begin
                  f1_next = 1'b0;
                  if (cmd.data[7:6] == 2'b10) begin
                    reg_we_next   = 1'b1;
                    reg_addr_next = cmd.data[5:0];
                    reg_data_next = b1_reg;
                  end else if (!cmd.data[7]) begin
                    va_we_next = 1'b1;
                    va_next    = {cmd.data[5:0], b1_reg};
                    va_wr_next = cmd.data[6];
                  end
                end
              end else begin
                f1_next       = 1'b0;
                stat_rd_next  = 1'b1;
                stat_sel_next = i_R15;
              end
            end

            PORT_PAL: begin
              if (cmd.wr) begin
                if (!f2_reg) begin
                  p1_next = cmd.data;
                  f2_next = 1'b1;
                end else begin
                  f2_next       = 1'b0;
                  pal_we_next   = 1'b1;
                  pal_addr_next = i_R16;
                  pal_data_next = pal_pack(p1_reg, cmd.data);
                end
              end
            end

            PORT_IND: begin
              // Target 17 would let the CPU rewrite the pointer it is using.
              if (cmd.wr && (i_R17[5:0] != REG_INDPTR)) begin
                reg_we_next   = 1'b1;
                reg_addr_next = i_R17[5:0];
                reg_data_next = cmd.data;
              end
            end

            default: ;
          endcase
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_EMUCLK) begin
    if (!i_RST_n) begin
      pend_reg     <= '0;
      f1_reg       <= 1'b0;
      f2_reg       <= 1'b0;
      b1_reg       <= 8'd0;
      p1_reg       <= 8'd0;
      reg_we_reg   <= 1'b0;
      reg_addr_reg <= 6'd0;
      reg_data_reg <= 8'd0;
      va_we_reg    <= 1'b0;
      va_reg       <= 14'd0;
      va_wr_reg    <= 1'b0;
      pal_we_reg   <= 1'b0;
      pal_addr_reg <= 4'd0;
      pal_data_reg <= 9'd0;
      stat_rd_reg  <= 1'b0;
      stat_sel_reg <= 4'd0;
      busy_reg     <= 1'b0;
    end else begin
      pend_reg     <= pend_next;
      f1_reg       <= f1_next;
      f2_reg       <= f2_next;
      b1_reg       <= b1_next;
      p1_reg       <= p1_next;
      reg_we_reg   <= reg_we_next;
      reg_addr_reg <= reg_addr_next;
      reg_data_reg <= reg_data_next;
      va_we_reg    <= va_we_next;
      va_reg       <= va_next;
      va_wr_reg    <= va_wr_next;
      pal_we_reg   <= pal_we_next;
      pal_addr_reg <= pal_addr_next;
      pal_data_reg <= pal_data_next;
      stat_rd_reg  <= stat_rd_next;
      stat_sel_reg <= stat_sel_next;
      busy_reg     <= busy_next;
    end
  end

  assign o_REG_WE   = reg_we_reg;
  assign o_REG_ADDR = reg_addr_reg;
  assign o_REG_DATA = reg_data_reg;
  assign o_VA_WE    = va_we_reg;
  assign o_VA       = va_reg;
  assign o_VA_WR    = va_wr_reg;
  assign o_PAL_WE   = pal_we_reg;
  assign o_PAL_ADDR = pal_addr_reg;
  assign o_PAL_DATA = pal_data_reg;
  assign o_STAT_RD  = stat_rd_reg;
  assign o_STAT_SEL = stat_sel_reg;
  assign o_BUSY     = busy_reg;

endmodule

// File: tb/tb_ika9958_regctrl.sv
// ---------------------------------------------------------------------------
// tb_ika9958_regctrl
// Directed stimulus with a scoreboard: each access that should produce an
// output pulse pushes the expected event (kind, edge number, address, data,
// BUSY) into a queue; a negedge monitor pops and compares every pulse the
// DUT presents.
// ---------------------------------------------------------------------------
module tb_ika9958_regctrl;

  localparam int K_REG  = 0;
  localparam int K_VA   = 1;
  localparam int K_PAL  = 2;
  localparam int K_STAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  port = 2'd0;
  logic [7:0]  di = 8'd0;
  logic [3:0]  r15 = 4'd0;
  logic [3:0]  r16 = 4'd0;
  logic [7:0]  r17 = 8'd0;

  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        va_we;
  logic [13:0] va;
  logic        va_wr;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [8:0]  pal_data;
  logic        stat_rd;
  logic [3:0]  stat_sel;
  logic        busy;

  ika9958_regctrl dut (
    .i_EMUCLK   (clk),
    .i_RST_n    (rst_n),
    .i_WR       (wr),
    .i_RD       (rd),
    .i_PORT     (port),
    .i_DI       (di),
    .i_R15      (r15),
    .i_R16      (r16),
    .i_R17      (r17),
    .o_REG_WE   (reg_we),
    .o_REG_ADDR (reg_addr),
    .o_REG_DATA (reg_data),
    .o_VA_WE    (va_we),
    .o_VA       (va),
    .o_VA_WR    (va_wr),
    .o_PAL_WE   (pal_we),
    .o_PAL_ADDR (pal_addr),
    .o_PAL_DATA (pal_data),
    .o_STAT_RD  (stat_rd),
    .o_STAT_SEL (stat_sel),
    .o_BUSY     (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k (and before the next), cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int cyc;
    int addr;
    int data;
    int busy;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input int at, input int addr,
                           input int data, input int bsy);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.addr = addr;
    e.data = data;
    e.busy = bsy;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic strobe(input logic [1:0] p, input logic w, input logic r, input logic [7:0] d);
    port = p;
    wr   = w;
    rd   = r;
    di   = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic wr1(input logic [1:0] p, input logic [7:0] d);
    strobe(p, 1'b1, 1'b0, d);
  endtask

  task automatic rd1(input logic [1:0] p);
    strobe(p, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pulses"}, {27'd0, reg_we, va_we, pal_we, stat_rd, busy}, 32'd0);
    chk({tag, "_reg"},    {18'd0, reg_addr, reg_data}, 32'd0);
    chk({tag, "_va"},     {17'd0, va, va_wr}, 32'd0);
    chk({tag, "_pal"},    {15'd0, pal_addr, pal_data, stat_sel}, 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    int  np;
    ev_t o;
    ev_t e;
    np = $countones({reg_we, va_we, pal_we, stat_rd});
    if (np > 1) chk("single_pulse", np, 1);
    if (np >= 1) begin
      o.cyc  = cyc;
      o.busy = int'(busy);
      if (reg_we) begin
        o.kind = K_REG;  o.addr = int'(reg_addr); o.data = int'(reg_data);
      end else if (va_we) begin
        o.kind = K_VA;   o.addr = int'(va);       o.data = int'(va_wr);
      end else if (pal_we) begin
        o.kind = K_PAL;  o.addr = int'(pal_addr); o.data = int'(pal_data);
      end else begin
        o.kind = K_STAT; o.addr = int'(stat_sel); o.data = 0;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_event: got kind=%0d cyc=%0d addr=0x%0h data=0x%0h busy=%0d, required no event",
                 o.kind, o.cyc, o.addr, o.data, o.busy);
      end else begin
        e = exp_q.pop_front();
        if (o.kind != e.kind || o.cyc != e.cyc || o.addr != e.addr ||
            o.data != e.data || o.busy != e.busy) begin
          n_fail++;
          $display("[TB] FAIL event: got kind=%0d cyc=%0d addr=0x%0h data=0x%0h busy=%0d, required kind=%0d cyc=%0d addr=0x%0h data=0x%0h busy=%0d",
                   o.kind, o.cyc, o.addr, o.data, o.busy, e.kind, e.cyc, e.addr, e.data, e.busy);
        end else begin
          $display("[TB] ev   kind=%0d cyc=%0d addr=0x%0h data=0x%0h busy=%0d ok",
                   o.kind, o.cyc, o.addr, o.data, o.busy);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    // Reset with a control-port write held on the pins: it must be ignored.
    rst_n = 1'b0;
    port  = 2'd1;
    wr    = 1'b1;
    di    = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Register write via control port, then F1 must be clear again.
    wr1(2'd1, 8'h5A);
    expect_ev(K_REG, cyc + 1, 7, 'h5A, 0);
    wr1(2'd1, 8'h87);
    wr1(2'd1, 8'h00);
    expect_ev(K_REG, cyc + 1, 0, 'h00, 0);
    wr1(2'd1, 8'h80);

    // VRAM setup, write and read direction.
    wr1(2'd1, 8'h34);
    expect_ev(K_VA, cyc + 1, 'h1234, 1, 0);
    wr1(2'd1, 8'h52);
    wr1(2'd1, 8'hCD);
    expect_ev(K_VA, cyc + 1, 'h0BCD, 0, 0);
    wr1(2'd1, 8'h0B);

    // Second byte 11xxxxxx is ignored but still closes the pair.
    wr1(2'd1, 8'h55);
    wr1(2'd1, 8'hC3);
    wr1(2'd1, 8'h44);
    expect_ev(K_REG, cyc + 1, 5, 'h44, 0);
    wr1(2'd1, 8'h85);

    // Control read clears F1 and reports the status pointer.
    r15 = 4'd2;
    wr1(2'd1, 8'h12);
    expect_ev(K_STAT, cyc + 1, 2, 0, 0);
    rd1(2'd1);
    wr1(2'd1, 8'h33);
    expect_ev(K_REG, cyc + 1, 1, 'h33, 0);
    wr1(2'd1, 8'h81);

    // Data-port write and read both clear F1.
    wr1(2'd1, 8'h66);
    wr1(2'd0, 8'h99);
    wr1(2'd1, 8'h77);
    expect_ev(K_REG, cyc + 1, 3, 'h77, 0);
    wr1(2'd1, 8'h83);
    wr1(2'd1, 8'h10);
    rd1(2'd0);
    wr1(2'd1, 8'h20);
    expect_ev(K_REG, cyc + 1, 4, 'h20, 0);
    wr1(2'd1, 8'h84);

    // WR and RD together count as a write (no status read).
    strobe(2'd1, 1'b1, 1'b1, 8'h5C);
    expect_ev(K_REG, cyc + 1, 6, 'h5C, 0);
    wr1(2'd1, 8'h86);
    idle(2);

    // Indirect write with auto-increment wrapping 63 -> 0.
    r17 = 8'h3F;
    expect_ev(K_REG, cyc + 1, 63, 'hAA, 1);
    expect_ev(K_REG, cyc + 2, 17, 'h00, 0);
    wr1(2'd3, 8'hAA);
    idle(3);

    // Target 17 is ignored entirely.
    r17 = 8'h91;
    wr1(2'd3, 8'h55);
    idle(3);

    // AII set: write without increment.
    r17 = 8'h85;
    expect_ev(K_REG, cyc + 1, 5, 'h42, 0);
    wr1(2'd3, 8'h42);
    idle(2);

    // Increment keeps bits 7:6.
    r17 = 8'h45;
    expect_ev(K_REG, cyc + 1, 5, 'h01, 1);
    expect_ev(K_REG, cyc + 2, 17, 'h46, 0);
    wr1(2'd3, 8'h01);
    idle(2);

    // Palette write with R#16 wrapping 15 -> 0.
    r16 = 4'd15;
    wr1(2'd2, 8'h73);
    expect_ev(K_PAL, cyc + 1, 15, 'h17B, 1);
    expect_ev(K_REG, cyc + 2, 16, 'h00, 0);
    wr1(2'd2, 8'h05);
    idle(2);

    // Palette write, then a status read parked during INC16.
    r16 = 4'd3;
    r15 = 4'd9;
    wr1(2'd2, 8'h07);
    expect_ev(K_PAL, cyc + 1, 3, 'h007, 1);
    expect_ev(K_REG, cyc + 2, 16, 'h04, 0);
    expect_ev(K_STAT, cyc + 3, 9, 0, 0);
    wr1(2'd2, 8'h60);
    rd1(2'd1);
    idle(3);

    // Strobe during INC17 is parked and run after BUSY falls; the next one
    // arrives while the buffer is still full and is dropped.
    r17 = 8'h08;
    expect_ev(K_REG, cyc + 1, 8, 'h11, 1);
    expect_ev(K_REG, cyc + 2, 17, 'h09, 0);
    expect_ev(K_REG, cyc + 3, 8, 'h22, 1);
    expect_ev(K_REG, cyc + 4, 17, 'h09, 0);
    wr1(2'd3, 8'h11);
    wr1(2'd3, 8'h22);
    wr1(2'd3, 8'h33);
    idle(4);

    // Reset during INC17 aborts the increment, wins over a strobe, clears F1.
    wr1(2'd1, 8'h12);
    r17 = 8'h02;
    expect_ev(K_REG, cyc + 1, 2, 'h77, 1);
    wr1(2'd3, 8'h77);
    rst_n = 1'b0;
    port  = 2'd3;
    wr    = 1'b1;
    di    = 8'hEE;
    @(posedge clk);
    #1;
    wr = 1'b0;
    @(negedge clk);
    check_zero("reset_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    wr1(2'd1, 8'h85);
    expect_ev(K_REG, cyc + 1, 1, 'h85, 0);
    wr1(2'd1, 8'h81);
    idle(5);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
